// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the instruction-fetch stage
package fetch_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_WAIT = 2'd2,
      S_SKID = 2'd3
   } fetch_state_e;

   localparam logic [31:0] FETCH_NOP_INST = 32'h0000_0013;
   localparam logic [31:0] FETCH_RESET_PC = 32'h0000_0000;
   localparam logic [31:0] PC_INCR        = 32'd4;
   localparam logic [31:0] PC_ALIGN_MASK  = 32'hFFFF_FFFC;

endpackage

// File: rtl/fetch_skid_buf.sv
// rtl/fetch_skid_buf.sv - one-entry {inst, pc} holding buffer used while decode stalls
module fetch_skid_buf (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_load,
   input  logic        i_unload,
   input  logic        i_clear,
   input  logic [31:0] i_inst,
   input  logic [31:0] i_pc,
   output logic        o_full,
   output logic [31:0] o_inst,
   output logic [31:0] o_pc
);

   logic        full_q;
   logic [31:0] inst_q;
   logic [31:0] pc_q;

   // Clear wins over load so a redirect always empties the buffer.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         full_q <= 1'b0;
         inst_q <= 32'd0;
         pc_q   <= 32'd0;
      end else if (i_clear) begin
         full_q <= 1'b0;
      end else if (i_load) begin
         full_q <= 1'b1;
         inst_q <= i_inst;
         pc_q   <= i_pc;
      end else if (i_unload) begin
         full_q <= 1'b0;
      end
   end

   assign o_full = full_q;
   assign o_inst = inst_q;
   assign o_pc   = pc_q;

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch: PC, single-outstanding imem handshake, IF/ID register
// Optional misaligned-redirect trap enabled by FETCH_MISALIGN_CHK_EN.
module fetch_stage
   import fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC = FETCH_RESET_PC,
   parameter logic [31:0] NOP_INST = FETCH_NOP_INST
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   output logic        o_imem_req,
   output logic [31:0] o_imem_addr,
   input  logic        i_imem_gnt,
   input  logic        i_imem_rvalid,
   input  logic [31:0] i_imem_rdata,
   input  logic        i_stall,
   input  logic        i_redirect,
   input  logic [31:0] i_redirect_pc,
   output logic        o_inst_valid,
   output logic [31:0] o_inst,
   output logic [31:0] o_inst_pc,
   output logic        o_misaligned
);

   fetch_state_e state_q, state_d;
   logic [31:0]  pc_q, pc_d;
   logic [31:0]  req_pc_q, req_pc_d;
   logic         drop_q, drop_d;
   logic [31:0]  inst_q, inst_d;
   logic [31:0]  inst_pc_q, inst_pc_d;
   logic         inst_valid_q, inst_valid_d;
   logic         skid_load, skid_unload, skid_clear, skid_full;
   logic [31:0]  skid_inst, skid_pc;
   logic         accept;

`ifdef FETCH_MISALIGN_CHK_EN
   logic         misaligned_q, misaligned_d;
`endif

   fetch_skid_buf u_skid (
      .i_clk    (i_clk),
      .i_rst_n  (i_rst_n),
      .i_load   (skid_load),
      .i_unload (skid_unload),
      .i_clear  (skid_clear),
      .i_inst   (i_imem_rdata),
      .i_pc     (req_pc_q),
      .o_full   (skid_full),
      .o_inst   (skid_inst),
      .o_pc     (skid_pc)
   );

   assign accept = !inst_valid_q || !i_stall;

   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      req_pc_d     = req_pc_q;
      drop_d       = drop_q;
      inst_d       = inst_q;
      inst_pc_d    = inst_pc_q;
      inst_valid_d = inst_valid_q;
      skid_load    = 1'b0;
      skid_unload  = 1'b0;
      skid_clear   = 1'b0;
`ifdef FETCH_MISALIGN_CHK_EN
      misaligned_d = misaligned_q;
`endif
      // Decode consumes the instruction whenever it is not stalling.
      if (!i_stall) begin
         inst_valid_d = 1'b0;
         inst_d       = NOP_INST;
      end

      case (state_q)
         S_IDLE: begin
`ifdef FETCH_MISALIGN_CHK_EN
            if (!misaligned_q) state_d = S_REQ;
`else
            state_d = S_REQ;
`endif
         end
         S_REQ: begin
            if (i_imem_gnt) begin
               req_pc_d = pc_q;
               pc_d     = pc_q + PC_INCR;
               state_d  = S_WAIT;
            end
         end
         S_WAIT: begin
            if (i_imem_rvalid) begin
               if (drop_q) begin
                  drop_d  = 1'b0;
                  state_d = S_REQ;
               end else if (accept) begin
                  inst_d       = i_imem_rdata;
                  inst_pc_d    = req_pc_q;
                  inst_valid_d = 1'b1;
                  state_d      = S_REQ;
               end else begin
                  skid_load = 1'b1;
                  state_d   = S_SKID;
               end
            end
         end
         S_SKID: begin
            if (!i_stall && skid_full) begin
               inst_d       = skid_inst;
               inst_pc_d    = skid_pc;
               inst_valid_d = 1'b1;
               skid_unload  = 1'b1;
               state_d      = S_REQ;
            end
         end
         default: state_d = S_IDLE;
      endcase

      // Redirect overrides everything computed above.
      if (i_redirect) begin
         pc_d         = i_redirect_pc & PC_ALIGN_MASK;
         inst_valid_d = 1'b0;
         inst_d       = NOP_INST;
         skid_load    = 1'b0;
         skid_unload  = 1'b0;
         skid_clear   = 1'b1;
         drop_d       = 1'b0;
         case (state_q)
            S_REQ: begin
               state_d = i_imem_gnt ? S_WAIT : S_REQ;
               drop_d  = i_imem_gnt;
            end
            S_WAIT: begin
               state_d = i_imem_rvalid ? S_REQ : S_WAIT;
               drop_d  = !i_imem_rvalid;
            end
            default: state_d = S_REQ;
         endcase
`ifdef FETCH_MISALIGN_CHK_EN
         if (i_redirect_pc[1:0] != 2'b00) begin
            misaligned_d = 1'b1;
            state_d      = S_IDLE;
            drop_d       = 1'b0;
         end else begin
            misaligned_d = 1'b0;
         end
`endif
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q      <= S_IDLE;
         pc_q         <= RESET_PC;
         req_pc_q     <= 32'd0;
         drop_q       <= 1'b0;
         inst_q       <= NOP_INST;
         inst_pc_q    <= 32'd0;
         inst_valid_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         req_pc_q     <= req_pc_d;
         drop_q       <= drop_d;
         inst_q       <= inst_d;
         inst_pc_q    <= inst_pc_d;
         inst_valid_q <= inst_valid_d;
      end
   end

`ifdef FETCH_MISALIGN_CHK_EN
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) misaligned_q <= 1'b0;
      else          misaligned_q <= misaligned_d;
   end
   assign o_misaligned = misaligned_q;
`else
   assign o_misaligned = 1'b0;
`endif

   assign o_imem_req   = (state_q == S_REQ);
   assign o_imem_addr  = pc_q;
   assign o_inst_valid = inst_valid_q;
   assign o_inst       = inst_q;
   assign o_inst_pc    = inst_pc_q;

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - directed self-checking bench for fetch_stage
module tb_fetch_stage;

   logic        clk;
   logic        rst_n;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic        stall;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        inst_valid;
   logic [31:0] inst;
   logic [31:0] inst_pc;
   logic        misaligned;

   int n_vec = 0;
   int n_err = 0;

   fetch_stage dut (
      .i_clk         (clk),
      .i_rst_n       (rst_n),
      .o_imem_req    (imem_req),
      .o_imem_addr   (imem_addr),
      .i_imem_gnt    (imem_gnt),
      .i_imem_rvalid (imem_rvalid),
      .i_imem_rdata  (imem_rdata),
      .i_stall       (stall),
      .i_redirect    (redirect),
      .i_redirect_pc (redirect_pc),
      .o_inst_valid  (inst_valid),
      .o_inst        (inst),
      .o_inst_pc     (inst_pc),
      .o_misaligned  (misaligned)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'd0;
      stall = 1'b0; redirect = 1'b0; redirect_pc = 32'd0;
      tick(); tick();
      chk("rst_req",   {31'd0, imem_req},   32'd0);
      chk("rst_valid", {31'd0, inst_valid}, 32'd0);
      chk("rst_inst",  inst,                32'h0000_0013);
      chk("rst_pc",    inst_pc,             32'd0);
      chk("rst_mis",   {31'd0, misaligned}, 32'd0);
      rst_n = 1'b1;

      // Back-to-back fetches: 0x0, 0x4, 0x8
      tick();
      chk("f0_req",  {31'd0, imem_req}, 32'd1);
      chk("f0_addr", imem_addr,         32'h0);
      imem_gnt = 1'b1;
      tick();
      imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'hA000_0000;
      chk("f0_wait_req", {31'd0, imem_req},   32'd0);
      chk("f0_not_yet",  {31'd0, inst_valid}, 32'd0);
      tick();
      chk("f0_valid", {31'd0, inst_valid}, 32'd1);
      chk("f0_inst",  inst,                32'hA000_0000);
      chk("f0_pc",    inst_pc,             32'h0);
      chk("f1_addr",  imem_addr,           32'h4);
      imem_rvalid = 1'b0; imem_gnt = 1'b1;
      tick();
      chk("f0_consumed", {31'd0, inst_valid}, 32'd0);
      imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'hA000_0001;
      tick();
      chk("f1_inst", inst,    32'hA000_0001);
      chk("f1_pc",   inst_pc, 32'h4);
      chk("f2_addr", imem_addr, 32'h8);
      imem_rvalid = 1'b0; imem_gnt = 1'b1;
      tick();
      imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'hA000_0002;
      tick();
      chk("f2_inst", inst,    32'hA000_0002);
      chk("f2_pc",   inst_pc, 32'h8);
      imem_rvalid = 1'b0;

      // Stall with IF/ID full: response goes to skid
      stall = 1'b1;
      chk("s_addr", imem_addr, 32'hC);
      imem_gnt = 1'b1;
      tick();
      imem_gnt = 1'b0;
      chk("s_hold_inst", inst, 32'hA000_0002);
      imem_rvalid = 1'b1; imem_rdata = 32'hA000_0003;
      tick();
      imem_rvalid = 1'b0;
      chk("s_skid_req",   {31'd0, imem_req},   32'd0);
      chk("s_skid_valid", {31'd0, inst_valid}, 32'd1);
      chk("s_skid_inst",  inst,                32'hA000_0002);
      chk("s_skid_pc",    inst_pc,             32'h8);
      tick();
      chk("s_skid_req2",  {31'd0, imem_req},   32'd0);
      chk("s_skid_inst2", inst,                32'hA000_0002);
      stall = 1'b0;
      tick();
      chk("s_out_valid", {31'd0, inst_valid}, 32'd1);
      chk("s_out_inst",  inst,                32'hA000_0003);
      chk("s_out_pc",    inst_pc,             32'hC);
      chk("s_next_req",  {31'd0, imem_req},   32'd1);
      chk("s_next_addr", imem_addr,           32'h10);

      // Redirect while waiting: late response dropped
      imem_gnt = 1'b1;
      tick();
      imem_gnt = 1'b0; redirect = 1'b1; redirect_pc = 32'h100;
      tick();
      redirect = 1'b0;
      chk("rw_req", {31'd0, imem_req}, 32'd0);
      imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
      tick();
      imem_rvalid = 1'b0;
      chk("rw_valid", {31'd0, inst_valid}, 32'd0);
      chk("rw_inst",  inst,                32'h0000_0013);
      chk("rw_req2",  {31'd0, imem_req},   32'd1);
      chk("rw_addr",  imem_addr,           32'h100);

      // Redirect while stalled with a valid instruction
      imem_gnt = 1'b1;
      tick();
      imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'hB000_0000;
      tick();
      imem_rvalid = 1'b0;
      chk("rs_pre_inst", inst,    32'hB000_0000);
      chk("rs_pre_pc",   inst_pc, 32'h100);
      stall = 1'b1; redirect = 1'b1; redirect_pc = 32'h200;
      tick();
      stall = 1'b0; redirect = 1'b0;
      chk("rs_valid", {31'd0, inst_valid}, 32'd0);
      chk("rs_inst",  inst,                32'h0000_0013);
      chk("rs_addr",  imem_addr,           32'h200);
      chk("rs_req",   {31'd0, imem_req},   32'd1);

      // Redirect coincident with grant
      imem_gnt = 1'b1; redirect = 1'b1; redirect_pc = 32'h300;
      tick();
      imem_gnt = 1'b0; redirect = 1'b0;
      chk("rg_req", {31'd0, imem_req}, 32'd0);
      imem_rvalid = 1'b1; imem_rdata = 32'hC000_0000;
      tick();
      imem_rvalid = 1'b0;
      chk("rg_valid", {31'd0, inst_valid}, 32'd0);
      chk("rg_inst",  inst,                32'h0000_0013);
      chk("rg_addr",  imem_addr,           32'h300);

      // rvalid outside S_WAIT is ignored
      imem_rvalid = 1'b1; imem_rdata = 32'hE000_0000;
      tick();
      imem_rvalid = 1'b0;
      chk("stray_valid", {31'd0, inst_valid}, 32'd0);
      chk("stray_req",   {31'd0, imem_req},   32'd1);

      // PC wraps past the top of the address space
      redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
      tick();
      redirect = 1'b0;
      chk("wrap_addr0", imem_addr, 32'hFFFF_FFFC);
      imem_gnt = 1'b1;
      tick();
      imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'hF000_0000;
      tick();
      imem_rvalid = 1'b0;
      chk("wrap_pc",   inst_pc,   32'hFFFF_FFFC);
      chk("wrap_addr", imem_addr, 32'h0);

      // Misaligned redirect
      redirect = 1'b1; redirect_pc = 32'h102;
      tick();
      redirect = 1'b0;
`ifdef FETCH_MISALIGN_CHK_EN
      chk("mis_set", {31'd0, misaligned}, 32'd1);
      chk("mis_req", {31'd0, imem_req},   32'd0);
      tick(); tick();
      chk("mis_req_hold", {31'd0, imem_req}, 32'd0);
      redirect = 1'b1; redirect_pc = 32'h104;
      tick();
      redirect = 1'b0;
      chk("mis_clr",  {31'd0, misaligned}, 32'd0);
      chk("mis_req2", {31'd0, imem_req},   32'd1);
      chk("mis_addr", imem_addr,           32'h104);
`else
      chk("mis_tied", {31'd0, misaligned}, 32'd0);
      chk("mis_req",  {31'd0, imem_req},   32'd1);
      chk("mis_addr", imem_addr,           32'h100);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
